// File: rtl/psram_bridge_pkg.sv
// Shared definitions for the PSRAM bridge: FSM encoding, read-latency bounds
// and a log2 helper used for lane-index sizing.
package psram_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StWait = 2'd2,
        StAck  = 2'd3
    } state_e;

    localparam int unsigned RdLatMin = 1;
    localparam int unsigned RdLatMax = 4;
    localparam int unsigned WaitCntW = 2;

    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned w = 1; w < value; w = w << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/psram_lane_steer.sv
// Byte steering between the 8-bit requester bus and a LANES-byte SRAM word:
// write byte replication and read lane selection.
module psram_lane_steer
    import psram_bridge_pkg::*;
#(
    parameter int unsigned LANES = 4,
    localparam int unsigned LBW = (log2_ceil(LANES) > 0) ? log2_ceil(LANES) : 1
) (
    input  logic [7:0]         wbyte,
    output logic [8*LANES-1:0] wword,
    input  logic [8*LANES-1:0] rword,
    input  logic [LBW-1:0]     lane,
    output logic [7:0]         rbyte
);

    assign wword = {LANES{wbyte}};

    always_comb begin
        rbyte = 8'h00;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane == i[LBW-1:0]) begin
                rbyte = rword[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/psram_bridge.sv
// Byte-wide requester to wide synchronous SRAM bridge with a single address window.
// Define PSRAM_BRIDGE_ERR_EN to answer out-of-window requests with memack+memerr.
module psram_bridge
    import psram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W   = 23,
    parameter int unsigned LANES    = 4,
    parameter int unsigned WORD_AW  = 13,
    parameter int unsigned WIN_BASE = 0,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   memaddr,
    input  logic [7:0]          memdatao,
    input  logic                memrd,
    input  logic                memwr,
    output logic                memack,
    output logic [7:0]          memdatai,
    output logic                memerr,
    output logic [WORD_AW-1:0]  sp_addr,
    output logic [8*LANES-1:0]  sp_datai,
    output logic [LANES-1:0]    sp_beb,
    output logic                sp_ceb,
    output logic                sp_web,
    input  logic [8*LANES-1:0]  sp_datao
);

    localparam int unsigned LB    = log2_ceil(LANES);
    localparam int unsigned LBW   = (LB > 0) ? LB : 1;
    localparam int unsigned WIN_W = ADDR_W - LB - WORD_AW;
    localparam int unsigned RdLat = (RD_LAT < RdLatMin) ? RdLatMin :
                                    (RD_LAT > RdLatMax) ? RdLatMax : RD_LAT;
    localparam logic [WaitCntW-1:0] WaitInit = WaitCntW'((RdLat > 1) ? RdLat - 2 : 0);

    logic [LBW-1:0]     lane;
    logic [WORD_AW-1:0] word;
    logic [WIN_W-1:0]   window;
    logic               in_win;
    logic               req;

    state_e             state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [LBW-1:0]     lane_q, lane_d;
    logic [WaitCntW-1:0] cnt_q, cnt_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [WORD_AW-1:0] sp_addr_q, sp_addr_d;
    logic [8*LANES-1:0] sp_datai_q, sp_datai_d;
    logic [LANES-1:0]   sp_beb_q, sp_beb_d;
    logic               sp_ceb_q, sp_ceb_d;
    logic               sp_web_q, sp_web_d;

    logic [8*LANES-1:0] rep_word;
    logic [7:0]         rd_byte;
    logic [7:0]         rd_value;
    logic               ack_rd;

    if (LB > 0) begin : g_lane
        assign lane = memaddr[LBW-1:0];
    end else begin : g_no_lane
        assign lane = '0;
    end

    assign word   = memaddr[LB+WORD_AW-1:LB];
    assign window = memaddr[ADDR_W-1:LB+WORD_AW];
    assign in_win = (window == WIN_W'(WIN_BASE));
    assign req    = memrd | memwr;

    psram_lane_steer #(
        .LANES (LANES)
    ) u_steer (
        .wbyte (memdatao),
        .wword (rep_word),
        .rword (sp_datao),
        .lane  (lane_q),
        .rbyte (rd_byte)
    );

`ifdef PSRAM_BRIDGE_ERR_EN
    logic err_q, err_d;

    always_ff @(posedge clkin) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign memerr   = (state_q == StAck) & err_q;
    assign rd_value = err_q ? 8'h00 : rd_byte;
`else
    assign memerr   = 1'b0;
    assign rd_value = rd_byte;
`endif

    // Read data is taken straight off the SRAM bus during ACK, then held.
    assign ack_rd   = (state_q == StAck) & ~op_wr_q;
    assign memdatai = ack_rd ? rd_value : rdata_q;
    assign rdata_d  = ack_rd ? rd_value : rdata_q;
    assign memack   = (state_q == StAck);

    assign sp_addr  = sp_addr_q;
    assign sp_datai = sp_datai_q;
    assign sp_beb   = sp_beb_q;
    assign sp_ceb   = sp_ceb_q;
    assign sp_web   = sp_web_q;

    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        sp_addr_d  = sp_addr_q;
        sp_datai_d = sp_datai_q;
        sp_beb_d   = '1;
        sp_ceb_d   = 1'b1;
        sp_web_d   = 1'b1;
`ifdef PSRAM_BRIDGE_ERR_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (in_win) begin
                        state_d    = StAcc;
                        op_wr_d    = memwr;
                        lane_d     = lane;
                        sp_ceb_d   = 1'b0;
                        sp_web_d   = ~memwr;
                        sp_beb_d   = ~(LANES'(1) << lane);
                        sp_addr_d  = word;
                        sp_datai_d = rep_word;
`ifdef PSRAM_BRIDGE_ERR_EN
                        err_d      = 1'b0;
`endif
                    end
`ifdef PSRAM_BRIDGE_ERR_EN
                    else begin
                        state_d = StAck;
                        op_wr_d = memwr;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            StAcc: begin
                cnt_d = WaitInit;
                if (op_wr_q || RdLat == 1) begin
                    state_d = StAck;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q    <= StIdle;
            op_wr_q    <= 1'b0;
            lane_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= 8'h00;
            sp_addr_q  <= '0;
            sp_datai_q <= '0;
            sp_beb_q   <= '1;
            sp_ceb_q   <= 1'b1;
            sp_web_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            sp_addr_q  <= sp_addr_d;
            sp_datai_q <= sp_datai_d;
            sp_beb_q   <= sp_beb_d;
            sp_ceb_q   <= sp_ceb_d;
            sp_web_q   <= sp_web_d;
        end
    end

endmodule

// File: tb/tb_psram_bridge.sv
// Directed bench for psram_bridge: a 4-lane RD_LAT=3 instance and an 8-lane
// RD_LAT=4 instance, each attached to a small behavioural synchronous SRAM.
module tb_psram_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: LANES=4, WORD_AW=13, RD_LAT=3
    logic        rst_a;
    logic [22:0] a_addr;
    logic [7:0]  a_wdata;
    logic        a_rd, a_wr, a_ack, a_err;
    logic [7:0]  a_rdata;
    logic [12:0] a_sp_addr;
    logic [31:0] a_sp_datai, a_sp_datao;
    logic [3:0]  a_sp_beb;
    logic        a_sp_ceb, a_sp_web;

    // Instance B: LANES=8, WORD_AW=12, RD_LAT=4
    logic        rst_b;
    logic [22:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_rd, b_wr, b_ack, b_err;
    logic [7:0]  b_rdata;
    logic [11:0] b_sp_addr;
    logic [63:0] b_sp_datai, b_sp_datao;
    logic [7:0]  b_sp_beb;
    logic        b_sp_ceb, b_sp_web;

    psram_bridge #(
        .ADDR_W (23), .LANES (4), .WORD_AW (13), .WIN_BASE (0), .RD_LAT (3)
    ) u_dut_a (
        .clkin (clk), .rst (rst_a), .memaddr (a_addr), .memdatao (a_wdata),
        .memrd (a_rd), .memwr (a_wr), .memack (a_ack), .memdatai (a_rdata),
        .memerr (a_err), .sp_addr (a_sp_addr), .sp_datai (a_sp_datai),
        .sp_beb (a_sp_beb), .sp_ceb (a_sp_ceb), .sp_web (a_sp_web),
        .sp_datao (a_sp_datao)
    );

    psram_bridge #(
        .ADDR_W (23), .LANES (8), .WORD_AW (12), .WIN_BASE (0), .RD_LAT (4)
    ) u_dut_b (
        .clkin (clk), .rst (rst_b), .memaddr (b_addr), .memdatao (b_wdata),
        .memrd (b_rd), .memwr (b_wr), .memack (b_ack), .memdatai (b_rdata),
        .memerr (b_err), .sp_addr (b_sp_addr), .sp_datai (b_sp_datai),
        .sp_beb (b_sp_beb), .sp_ceb (b_sp_ceb), .sp_web (b_sp_web),
        .sp_datao (b_sp_datao)
    );

    // Behavioural SRAMs: command sampled at the edge, read data appears RD_LAT edges later.
    logic [31:0] mem_a [0:8191];
    logic [31:0] a_pipe [0:2];
    always @(posedge clk) begin
        if (a_sp_ceb === 1'b0 && a_sp_web === 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (!a_sp_beb[i]) mem_a[a_sp_addr][8*i +: 8] <= a_sp_datai[8*i +: 8];
            end
        end
        if (a_sp_ceb === 1'b0 && a_sp_web === 1'b1) a_pipe[0] <= mem_a[a_sp_addr];
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
    end
    assign a_sp_datao = a_pipe[2];

    logic [63:0] mem_b [0:4095];
    logic [63:0] b_pipe [0:3];
    always @(posedge clk) begin
        if (b_sp_ceb === 1'b0 && b_sp_web === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                if (!b_sp_beb[i]) mem_b[b_sp_addr][8*i +: 8] <= b_sp_datai[8*i +: 8];
            end
        end
        if (b_sp_ceb === 1'b0 && b_sp_web === 1'b1) b_pipe[0] <= mem_b[b_sp_addr];
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
        b_pipe[3] <= b_pipe[2];
    end
    assign b_sp_datao = b_pipe[3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_start(input logic rd, input logic wr, input logic [22:0] addr,
                           input logic [7:0] d);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = d;
        @(posedge clk); #1;
    endtask

    task automatic a_wait(output int lat, output logic [7:0] rv, output logic ev);
        int k;
        lat = 0; rv = 8'h00; ev = 1'b0; k = 1;
        while (lat == 0 && k <= 40) begin
            if (a_ack === 1'b1) begin
                lat = k; rv = a_rdata; ev = a_err;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
    endtask

    task automatic a_end();
        a_rd = 1'b0; a_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic b_start(input logic rd, input logic wr, input logic [22:0] addr,
                           input logic [7:0] d);
        b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = d;
        @(posedge clk); #1;
    endtask

    task automatic b_wait(output int lat, output logic [7:0] rv, output logic ev);
        int k;
        lat = 0; rv = 8'h00; ev = 1'b0; k = 1;
        while (lat == 0 && k <= 40) begin
            if (b_ack === 1'b1) begin
                lat = k; rv = b_rdata; ev = b_err;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
    endtask

    task automatic b_end();
        b_rd = 1'b0; b_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [7:0]  rv;
        logic        ev;
        logic        seen_ack, seen_ce;
        logic [7:0]  d, eb;

        a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        rst_a = 1; rst_b = 1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_memack", 64'(a_ack), 64'd0);
        check("rst_memerr", 64'(a_err), 64'd0);
        check("rst_memdatai", 64'(a_rdata), 64'd0);
        check("rst_ceb", 64'(a_sp_ceb), 64'd1);
        check("rst_web", 64'(a_sp_web), 64'd1);
        check("rst_beb", 64'(a_sp_beb), 64'hF);
        check("rst_addr", 64'(a_sp_addr), 64'd0);
        check("rst_datai", 64'(a_sp_datai), 64'd0);
        rst_a = 0; rst_b = 0;
        @(posedge clk); #1;

        // Write 0x000005 <- 0xA5
        a_start(1'b0, 1'b1, 23'h000005, 8'hA5);
        check("wr_ceb", 64'(a_sp_ceb), 64'd0);
        check("wr_web", 64'(a_sp_web), 64'd0);
        check("wr_beb", 64'(a_sp_beb), 64'b1101);
        check("wr_addr", 64'(a_sp_addr), 64'd1);
        check("wr_datai", 64'(a_sp_datai), 64'hA5A5A5A5);
        a_wait(lat, rv, ev);
        check("wr_lat", 64'(lat), 64'd2);
        check("wr_err", 64'(ev), 64'd0);
        check("wr_ack_ceb", 64'(a_sp_ceb), 64'd1);
        a_end();
        check("wr_ack_once", 64'(a_ack), 64'd0);

        // Read 0x000005, RD_LAT=3
        a_start(1'b1, 1'b0, 23'h000005, 8'h00);
        check("rd_ceb", 64'(a_sp_ceb), 64'd0);
        check("rd_web", 64'(a_sp_web), 64'd1);
        check("rd_beb", 64'(a_sp_beb), 64'b1101);
        a_wait(lat, rv, ev);
        check("rd_lat", 64'(lat), 64'd4);
        check("rd_data", 64'(rv), 64'hA5);
        check("rd_err", 64'(ev), 64'd0);
        a_end();
        check("rd_ack_once", 64'(a_ack), 64'd0);
        check("rd_hold", 64'(a_rdata), 64'hA5);

        // memrd and memwr together act as a write
        a_start(1'b1, 1'b1, 23'h000010, 8'h3C);
        check("rw_web", 64'(a_sp_web), 64'd0);
        check("rw_addr", 64'(a_sp_addr), 64'd4);
        check("rw_beb", 64'(a_sp_beb), 64'b1110);
        a_wait(lat, rv, ev);
        check("rw_lat", 64'(lat), 64'd2);
        a_end();
        check("rw_hold_prev_read", 64'(a_rdata), 64'hA5);
        a_start(1'b1, 1'b0, 23'h000010, 8'h00);
        a_wait(lat, rv, ev);
        check("rw_rd_lat", 64'(lat), 64'd4);
        check("rw_rd_data", 64'(rv), 64'h3C);
        a_end();

        // Out-of-window read
        a_start(1'b1, 1'b0, 23'h008000, 8'h00);
`ifdef PSRAM_BRIDGE_ERR_EN
        check("oow_ack", 64'(a_ack), 64'd1);
        check("oow_err", 64'(a_err), 64'd1);
        check("oow_data", 64'(a_rdata), 64'd0);
        check("oow_ceb", 64'(a_sp_ceb), 64'd1);
        a_end();
        check("oow_ack_once", 64'(a_ack), 64'd0);
`else
        seen_ack = 1'b0; seen_ce = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (a_ack !== 1'b0) seen_ack = 1'b1;
            if (a_sp_ceb !== 1'b1) seen_ce = 1'b1;
            @(posedge clk); #1;
        end
        check("oow_no_ack", 64'(seen_ack), 64'd0);
        check("oow_no_ceb", 64'(seen_ce), 64'd0);
        check("oow_err", 64'(a_err), 64'd0);
        a_end();
`endif
        a_start(1'b1, 1'b0, 23'h000005, 8'h00);
        a_wait(lat, rv, ev);
        check("post_oow_lat", 64'(lat), 64'd4);
        check("post_oow_data", 64'(rv), 64'hA5);
        a_end();

        // Reset during WAIT of an RD_LAT=4 read
        b_start(1'b0, 1'b1, 23'h000020, 8'h5A);
        b_wait(lat, rv, ev);
        check("b_wr_lat", 64'(lat), 64'd2);
        b_end();
        b_start(1'b1, 1'b0, 23'h000020, 8'h00);
        check("b_rd_ceb", 64'(b_sp_ceb), 64'd0);
        @(posedge clk); #1;
        rst_b = 1; b_rd = 0;
        @(posedge clk); #1;
        rst_b = 0;
        check("rstw_ack", 64'(b_ack), 64'd0);
        check("rstw_err", 64'(b_err), 64'd0);
        check("rstw_data", 64'(b_rdata), 64'd0);
        check("rstw_ceb", 64'(b_sp_ceb), 64'd1);
        check("rstw_web", 64'(b_sp_web), 64'd1);
        check("rstw_beb", 64'(b_sp_beb), 64'hFF);
        check("rstw_addr", 64'(b_sp_addr), 64'd0);
        check("rstw_datai", 64'(b_sp_datai), 64'd0);
        seen_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (b_ack !== 1'b0) seen_ack = 1'b1;
            @(posedge clk); #1;
        end
        check("rstw_no_ack", 64'(seen_ack), 64'd0);
        b_start(1'b1, 1'b0, 23'h000020, 8'h00);
        b_wait(lat, rv, ev);
        check("rstw_rd_lat", 64'(lat), 64'd5);
        check("rstw_rd_data", 64'(rv), 64'h5A);
        b_end();

        // Ten back-to-back writes then reads, LANES=8
        for (int i = 0; i < 10; i++) begin
            d  = 8'hC0 + 8'(i);
            eb = ~(8'h01 << (i % 8));
            b_start(1'b0, 1'b1, 23'(i), d);
            check("b2b_wr_ceb", 64'(b_sp_ceb), 64'd0);
            check("b2b_wr_beb", 64'(b_sp_beb), 64'(eb));
            check("b2b_wr_addr", 64'(b_sp_addr), 64'(i / 8));
            check("b2b_wr_datai", b_sp_datai, {8{d}});
            b_wait(lat, rv, ev);
            check("b2b_wr_lat", 64'(lat), 64'd2);
            b_end();
        end
        for (int i = 0; i < 10; i++) begin
            eb = ~(8'h01 << (i % 8));
            b_start(1'b1, 1'b0, 23'(i), 8'h00);
            check("b2b_rd_ceb", 64'(b_sp_ceb), 64'd0);
            check("b2b_rd_beb", 64'(b_sp_beb), 64'(eb));
            b_wait(lat, rv, ev);
            check("b2b_rd_lat", 64'(lat), 64'd5);
            check("b2b_rd_data", 64'(rv), 64'(8'hC0 + 8'(i)));
            check("b2b_rd_err", 64'(ev), 64'd0);
            b_end();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psram_bridge.md
PSRAM_BRIDGE -- requirements
Module: psram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, requester byte-address width.
REQ-002 SHALL have parameter LANES, default 4, byte lanes per SRAM word (power of 2, 1..8); LB = log2(LANES).
REQ-003 SHALL have parameter WORD_AW, default 13, SRAM word-address width; ADDR_W > LB+WORD_AW.
REQ-004 SHALL have parameter WIN_BASE, default 0, window index compared against memaddr[ADDR_W-1:LB+WORD_AW].
REQ-005 SHALL have parameter RD_LAT, default 1, SRAM read latency in cycles (1..4).
REQ-006 SHALL have ports: clkin in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-007 SHALL have ports: memaddr in ADDR_W byte address; memdatao in 8 write byte; memrd in 1 read request; memwr in 1 write request.
REQ-008 SHALL have ports: memack out 1 one-cycle completion pulse; memdatai out 8 read byte; memerr out 1 error flag qualified by memack.
REQ-009 SHALL have ports: sp_addr out WORD_AW; sp_datai out 8*LANES; sp_beb out LANES (active-low byte enables); sp_ceb out 1 (active-low); sp_web out 1 (active-low); sp_datao in 8*LANES.

Function
REQ-010 SHALL decode lane = memaddr[LB-1:0], word = memaddr[LB+WORD_AW-1:LB], window = upper bits; in-window iff window == WIN_BASE.
REQ-011 SHALL run FSM IDLE -> ACC -> (WAIT x RD_LAT-1, reads only) -> ACK -> IDLE.
REQ-012 SHALL in IDLE accept a request when memrd|memwr is high, capturing address, data, lane and op; later input changes are ignored until ACK.
REQ-013 SHALL treat memrd and memwr high together as a write.
REQ-014 SHALL in ACC drive registered sp_ceb=0, sp_addr=word, sp_beb one-cold at lane, sp_web=0 for write/1 for read, sp_datai = memdatao replicated LANES times; all strobes inactive in every other state.
REQ-015 SHALL for a write accepted at edge N pulse memack during cycle N+2.
REQ-016 SHALL for a read accepted at edge N pulse memack during cycle N+1+RD_LAT, with memdatai = captured lane of sp_datao, held until the next read completes.
REQ-017 SHALL keep memack high for exactly one cycle; the requester drops its strobe the cycle after memack, and IDLE re-samples then, so back-to-back accesses run with no extra gap.
REQ-018 SHALL keep memerr 0 for in-window accesses.
REQ-019 SHALL never assert SRAM strobes for out-of-window accesses.

Reset
REQ-020 SHALL on rst high at a clkin edge force IDLE, memack=0, memerr=0, memdatai=0, sp_ceb=1, sp_web=1, sp_beb all 1, sp_addr=0, sp_datai=0.
REQ-021 SHALL abandon any in-flight access on reset without an ack; a write is committed iff its ACC cycle completed before the reset edge.

Configuration
REQ-022 SHALL, with PSRAM_BRIDGE_ERR_EN defined, answer out-of-window requests by going IDLE -> ACK: memack one cycle after acceptance, memerr=1, memdatai=0 for reads.
REQ-023 SHALL, without PSRAM_BRIDGE_ERR_EN, ignore out-of-window requests (stay IDLE, no memack); memerr is tied to 0.

Structure
REQ-024 SHALL place the FSM state encoding, RD_LAT bounds and a log2 helper in shared package psram_bridge_pkg.
REQ-025 SHALL implement byte replication and read-lane mux in sub-module psram_lane_steer (parameter LANES).

Verification
REQ-026 Default params, write memaddr=0x000005 data 0xA5 -> sp_beb=1101, sp_addr=1, sp_datai=0xA5A5A5A5 in ACC, memack 2 cycles after accept, memerr=0.
REQ-027 Read 0x000005 after REQ-026 with RD_LAT=3 -> memack 4 cycles after accept, memdatai=0xA5.
REQ-028 memrd=memwr=1 at 0x000010 data 0x3C -> write performed (sp_web=0); subsequent read returns 0x3C.
REQ-029 Read 0x008000 -> with PSRAM_BRIDGE_ERR_EN: memack next cycle, memerr=1, memdatai=0, sp_ceb stays 1; without: no memack for 20 cycles, sp_ceb stays 1.
REQ-030 rst pulsed during WAIT of a RD_LAT=4 read -> no memack, all outputs at reset values next cycle; a following read completes normally.
REQ-031 LANES=8, WORD_AW=12: ten back-to-back writes to bytes 0..9 then reads -> correct one-cold sp_beb per lane, word wrap at byte 8, all data matches, no idle gap between accesses.
